// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter plus UART frame sequencer that owns the
// shared TX line. A grant captures the winner's byte, then the frame
// (start, data LSB first, optional parity, stop) is shifted out on txd with
// CLKS_PER_BIT clocks per bit. Back-to-back frames are granted in the last
// stop-bit cycle so the line never idles between queued frames.
`timescale 1ns/1ps
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ID_W-1:0]           gnt_id,
  output logic                      txd,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam logic             ODD_BIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_q, par_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                txd_q, txd_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic                win_vld;
  logic [ID_W-1:0]     win_id;
  logic [DATA_W-1:0]   win_data;
  int                  cand;
  logic                bit_end;
  logic                take_grant;

  // Round-robin pick: first pending request at or above rr_ptr, wrapping at
  // NUM_REQ. Scanning distances from far to near lets the nearest one win.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_data = '0;
    cand     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (1'(req >> cand)) begin
        win_vld  = 1'b1;
        win_id   = ID_W'(cand);
        win_data = DATA_W'(req_data >> (cand * DATA_W));
      end
    end
  end

  // Frame sequencer: next state, bit timing, line value and grant bookkeeping.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    rr_ptr_d     = rr_ptr_q;
    txd_d        = txd_q;
    gnt_d        = '0;
    gnt_id_d     = gnt_id_q;
    frame_done_d = 1'b0;
    take_grant   = 1'b0;
    bit_end      = (tmr_q == TMR_LAST);

    if (state_q != S_IDLE) begin
      tmr_d = bit_end ? '0 : tmr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (en && win_vld) begin
          take_grant = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          txd_d   = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          frame_done_d = 1'b1;
          if (en && win_vld) begin
            take_grant = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (take_grant) begin
      state_d  = S_START;
      txd_d    = 1'b0;
      shreg_d  = win_data;
      par_d    = (^win_data) ^ ODD_BIT;
      gnt_d    = NUM_REQ'(1) << win_id;
      gnt_id_d = win_id;
      rr_ptr_d = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset forces the line idle-high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      idx_q        <= '0;
      rr_ptr_q     <= '0;
      txd_q        <= 1'b1;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      idx_q        <= idx_d;
      rr_ptr_q     <= rr_ptr_d;
      txd_q        <= txd_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Captured byte and its parity; only read after a grant reloads them.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  assign gnt        = gnt_q;
  assign gnt_id     = gnt_id_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: scoreboard of expected grants/frames checked
// by a monitor, plus parity-variant instances checked against a line model.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int CPB  = 16;
  localparam int FLEN = 176;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        txd, busy, frame_done;

  logic        en_v;
  logic [3:0]  req_o, req_n;
  logic [31:0] req_data_o, req_data_n;
  logic [3:0]  gnt_o, gnt_n;
  logic [1:0]  gnt_id_o, gnt_id_n;
  logic        txd_o, busy_o, fd_o, txd_n, busy_n, fd_n;

  always #5 clk = ~clk;

  uart_tx_sched dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt), .gnt_id(gnt_id), .txd(txd), .busy(busy), .frame_done(frame_done)
  );

  uart_tx_sched #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .en(en_v), .req(req_o), .req_data(req_data_o),
    .gnt(gnt_o), .gnt_id(gnt_id_o), .txd(txd_o), .busy(busy_o), .frame_done(fd_o)
  );

  uart_tx_sched #(.PARITY_EN(0), .PARITY_ODD(0)) u_np (
    .clk(clk), .reset(reset), .en(en_v), .req(req_n), .req_data(req_data_n),
    .gnt(gnt_n), .gnt_id(gnt_id_n), .txd(txd_n), .busy(busy_n), .frame_done(fd_n)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   left[4];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: value of txd in frame cycle c (cycle 0 = grant cycle).
  function automatic logic exp_txd(input logic [7:0] d, input bit pen, input bit podd, input int c);
    int slot;
    slot = c / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return 1'(d >> (slot - 1));
    if (pen && slot == 9) return (^d) ^ podd;
    return 1'b1;
  endfunction

  task automatic push(input int id, input logic [7:0] d, input bit b2b);
    exp_t e;
    e.id = id; e.data = d; e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  // Drives requests until every requester used up its grant budget and the
  // block is idle again.
  task automatic serve(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i[1:0]]) begin
          left[i]--;
          if (left[i] <= 0) req[i[1:0]] = 1'b0;
        end
      end
      if (req == 4'b0 && busy == 1'b0) done = 1'b1;
    end
    check_eq("serve_done", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_gnt(input int max_cyc);
    bit got;
    got = 1'b0;
    for (int n = 0; n < max_cyc && !got; n++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0) got = 1'b1;
    end
    check_eq("gnt_wait", {31'b0, got}, 32'd1);
  endtask

  // Monitor: on every grant pop the expected frame and check it cycle by cycle.
  initial begin : monitor
    exp_t       cur;
    int         cyc;
    bit         in_frame, at_end, slot_bad, ctrl_bad;
    logic       e;
    logic [3:0] gexp;
    in_frame = 1'b0; cyc = 0; slot_bad = 1'b0; ctrl_bad = 1'b0;
    cur.id = 0; cur.data = 8'h00; cur.b2b = 1'b0;
    forever begin
      @(negedge clk);
      at_end = 1'b0;
      if (reset !== 1'b1) begin
        in_frame = 1'b0;
      end else begin
        if (in_frame) begin
          cyc++;
          if (cyc < FLEN) begin
            e = exp_txd(cur.data, 1'b1, 1'b0, cyc);
            if (cyc % CPB == 0) slot_bad = (txd !== e);
            else slot_bad = slot_bad | (txd !== e);
            if (gnt !== 4'b0 || busy !== 1'b1 || frame_done !== 1'b0) ctrl_bad = 1'b1;
            if (cyc % CPB == CPB - 1)
              check_eq($sformatf("txd_slot%0d_req%0d", cyc / CPB, cur.id), {31'b0, slot_bad}, 32'd0);
          end else begin
            check_eq("frame_done", {31'b0, frame_done}, 32'd1);
            check_eq("frame_ctrl", {31'b0, ctrl_bad}, 32'd0);
            if (gnt === 4'b0) begin
              check_eq("idle_busy", {31'b0, busy}, 32'd0);
              check_eq("idle_txd", {31'b0, txd}, 32'd1);
            end
            in_frame = 1'b0;
            at_end   = 1'b1;
          end
        end else if (frame_done !== 1'b0) begin
          check_eq("spurious_frame_done", {31'b0, frame_done}, 32'd0);
        end
        if (gnt !== 4'b0 && !in_frame) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_gnt", {28'b0, gnt}, 32'd0);
          end else begin
            cur  = exp_q.pop_front();
            gexp = 4'b0001 << cur.id;
            check_eq("gnt_onehot", {28'b0, gnt}, {28'b0, gexp});
            check_eq("gnt_id", {30'b0, gnt_id}, cur.id);
            check_eq("b2b", {31'b0, at_end}, {31'b0, cur.b2b});
            in_frame = 1'b1;
            cyc      = 0;
            slot_bad = (txd !== 1'b0);
            ctrl_bad = (busy !== 1'b1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   cnt;
    bit   got;
    logic wo[0:180], wn[0:180], fdo[0:180], fdn[0:180], bn[0:180];
    bit   bad;

    reset = 1'b0; en = 1'b0; req = 4'b0; req_data = 32'h0; en_v = 1'b1;
    req_o = 4'b0; req_n = 4'b0; req_data_o = 32'h0; req_data_n = 32'h0;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_txd", {31'b0, txd}, 32'd1);
    check_eq("rst_gnt", {28'b0, gnt}, 32'd0);
    check_eq("rst_gnt_id", {30'b0, gnt_id}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_frame_done", {31'b0, frame_done}, 32'd0);
    reset = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk); #1;

    // All four requesting; requester 0 keeps asking for a second frame.
    req_data = 32'h44332211;
    push(0, 8'h11, 1'b0); push(1, 8'h22, 1'b1); push(2, 8'h33, 1'b1);
    push(3, 8'h44, 1'b1); push(0, 8'h11, 1'b1);
    left = '{2, 1, 1, 1};
    req = 4'b1111;
    serve(1200);

    // Single frame 0xA5 from requester 0.
    req_data[7:0] = 8'hA5;
    push(0, 8'hA5, 1'b0);
    left = '{1, 0, 0, 0};
    req = 4'b0001;
    serve(300);

    // Grant 2, then 3 and 0 pending together: pointer wraps 3 -> 0.
    req_data = 32'h966B223C;
    push(2, 8'h6B, 1'b0);
    left = '{0, 0, 1, 0};
    req = 4'b0100;
    serve(300);
    push(3, 8'h96, 1'b0); push(0, 8'h3C, 1'b1);
    left = '{1, 0, 0, 1};
    req = 4'b1001;
    serve(600);

    // Enable gating.
    en = 1'b0; req = 4'b0010; cnt = 0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0) cnt++;
    end
    check_eq("en0_nogrant", cnt, 32'd0);
    check_eq("en0_busy", {31'b0, busy}, 32'd0);
    push(1, 8'h22, 1'b0);
    en = 1'b1;
    @(posedge clk); #1;
    check_eq("en_rise_gnt", {28'b0, gnt}, 32'h2);
    req = 4'b0;
    repeat (80) @(posedge clk); #1;
    en = 1'b0; req = 4'b0100;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) got = 1'b1;
    end
    check_eq("en_drop_completes", {31'b0, got}, 32'd1);
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0 || busy !== 1'b0) cnt++;
    end
    check_eq("en_drop_no_regrant", cnt, 32'd0);
    check_eq("gnt_id_hold", {30'b0, gnt_id}, 32'd1);
    req = 4'b0; en = 1'b1;

    // Reset in the middle of a frame from requester 1 (data 0x5A).
    req_data[15:8] = 8'h5A;
    push(1, 8'h5A, 1'b0);
    req = 4'b0010;
    wait_gnt(10);
    req = 4'b0;
    repeat (50) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_txd", {31'b0, txd}, 32'd1);
    check_eq("async_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("async_rst_gnt", {28'b0, gnt}, 32'd0);
    check_eq("async_rst_gnt_id", {30'b0, gnt_id}, 32'd0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) cnt++;
    end
    check_eq("post_reset_idle", cnt, 32'd0);
    req_data[7:0] = 8'hC4;
    push(0, 8'hC4, 1'b0);
    req = 4'b1001;
    wait_gnt(10);
    check_eq("rr_after_reset", {28'b0, gnt}, 32'h1);
    req = 4'b0;
    serve(300);

    // Parity variants: odd parity on 0x00, no parity on 0xFF.
    req_data_o = 32'h0; req_data_n = 32'h000000FF;
    @(posedge clk); #1;
    req_o = 4'b0001; req_n = 4'b0001;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (gnt_o !== 4'b0) got = 1'b1;
    end
    check_eq("var_gnt_seen", {31'b0, got}, 32'd1);
    check_eq("var_np_gnt", {28'b0, gnt_n}, 32'h1);
    req_o = 4'b0; req_n = 4'b0;
    for (int c = 0; c <= 180; c++) begin
      wo[c] = txd_o; wn[c] = txd_n; fdo[c] = fd_o; fdn[c] = fd_n; bn[c] = busy_n;
      @(negedge clk);
    end
    for (int s = 0; s < 11; s++) begin
      bad = 1'b0;
      for (int c = s * CPB; c < (s + 1) * CPB; c++) bad = bad | (wo[c] !== exp_txd(8'h00, 1'b1, 1'b1, c));
      check_eq($sformatf("odd_slot%0d", s), {31'b0, bad}, 32'd0);
    end
    for (int s = 0; s < 10; s++) begin
      bad = 1'b0;
      for (int c = s * CPB; c < (s + 1) * CPB; c++) bad = bad | (wn[c] !== exp_txd(8'hFF, 1'b0, 1'b0, c));
      check_eq($sformatf("nopar_slot%0d", s), {31'b0, bad}, 32'd0);
    end
    check_eq("odd_parity_bit", {31'b0, wo[152]}, 32'd1);
    check_eq("odd_done_early", {31'b0, fdo[175]}, 32'd0);
    check_eq("odd_done_176", {31'b0, fdo[176]}, 32'd1);
    check_eq("nopar_done_early", {31'b0, fdn[159]}, 32'd0);
    check_eq("nopar_done_160", {31'b0, fdn[160]}, 32'd1);
    check_eq("nopar_busy_159", {31'b0, bn[159]}, 32'd1);
    check_eq("nopar_busy_160", {31'b0, bn[160]}, 32'd0);
    check_eq("nopar_idle_txd", {31'b0, wn[170]}, 32'd1);

    repeat (5) @(posedge clk);
    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler and frame sequencer that shares one UART transmit line between NUM_REQ requesters. It arbitrates among the pending requests and captures the winner's byte. It then sequences the serial frame on txd (start, data LSB first, optional parity, stop) with bit timing derived from clk. It sits beside the UART receive path and is the single owner of the TX line.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of gnt_id; 2**ID_W >= NUM_REQ
DATA_W, 8, data bits per frame (5..8)
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
PARITY_EN, 1, 1 = parity bit present, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  1 = new grants allowed; 0 = no new grants, the current frame still completes
req  input  NUM_REQ  request per requester; held high with stable data until its gnt bit is seen
req_data  input  NUM_REQ*DATA_W  requester i data on bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot, one-cycle pulse; data of that requester was captured
gnt_id  output  ID_W  index of the requester currently or last granted
txd  output  1  serial line, idle high
busy  output  1  1 while a frame is in progress (state != IDLE)
frame_done  output  1  one-cycle pulse in the cycle after the last stop-bit cycle

Behaviour:
- Reset (async, active-low): state=IDLE, txd=1, gnt=0, gnt_id=0, busy=0, frame_done=0, rr_ptr=0, bit timer=0, bit index=0.
- All outputs are registered; there is no combinational path from req to gnt.
- States: IDLE, START, DATA, PARITY, STOP.
- Bit timer counts 0..CLKS_PER_BIT-1 in every non-IDLE state. A bit ends when the timer reaches CLKS_PER_BIT-1; the timer then wraps to 0.
- Grant point, taken at an edge where en=1 and |req=1, in either case:
  - state=IDLE, or
  - the last STOP cycle.
- At the grant point:
  - winner = first set req bit searching from rr_ptr upward, with wrap-around.
  - Capture req_data of the winner into the shift register.
  - gnt[winner]=1 for exactly one cycle; gnt_id=winner; rr_ptr=(winner+1) mod NUM_REQ.
  - state=START, txd=0, busy=1.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - txd = data bit[idx], LSB first; each bit held CLKS_PER_BIT cycles.
  - After bit DATA_W-1, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: txd = (^data) XOR PARITY_ODD, computed on the captured byte; held CLKS_PER_BIT cycles, then go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. At the end of the last cycle:
  - frame_done pulses in the next cycle.
  - If the grant condition holds, a new frame starts back-to-back: the gnt pulse coincides with frame_done and there is no idle-high gap.
  - Otherwise state=IDLE and busy=0.
- Frame length = (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles; 176 for the defaults.
- req is sampled only at grant points. Changes of req or req_data mid-frame have no effect on the frame in progress.
- en=0 blocks grants only. Dropping en mid-frame does not truncate the frame. Raising en while in IDLE with req pending gives a grant at the next edge.
- A req bit deasserted before its grant is never granted. A requester holding req high across frames is re-granted only after every other pending requester has been served (round-robin).
- Reset asserted mid-frame: txd returns to 1 immediately (async), the frame is abandoned, and no frame_done is produced. After release the block is in IDLE and behaves as after power-up.
- NUM_REQ less than 2**ID_W: unused pointer values never occur, because rr_ptr wraps at NUM_REQ.

Test Plan:
- Defaults; req=0001, req_data[7:0]=0xA5 -> gnt=0001 for 1 cycle with txd=0 in that same cycle. Then:
  - start 0 for cycles 0-15;
  - data 1,0,1,0,0,1,0,1 at 16 cycles each;
  - parity 0 for cycles 144-159;
  - stop 1 for cycles 160-175;
  - frame_done and busy=0 in cycle 176.
- req=1111 held, data 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3, each 176 cycles apart. Each gnt coincides with the previous frame_done, txd has no idle-high gap, and gnt_id tracks the grants.
- After a grant to 2, assert req=1001 -> requester 3 granted first, then requester 0; rr_ptr wraps 3 -> 0.
- PARITY_ODD=1, data 0x00 -> parity bit 1. PARITY_EN=0, data 0xFF -> frame is 160 cycles with no parity slot.
- Reset pulled low at cycle 50 of a frame -> txd=1, busy=0, gnt=0 asynchronously, and no frame_done. With req=0 after release, txd stays 1.
- en=0 with req=0010 -> no gnt for 500 cycles; raising en gives a grant at the next edge. Dropping en at cycle 80 of a frame -> the frame completes to 176 cycles, then the block goes to IDLE with no new grant.
